// File: rtl/usi_bus_matrix_if.sv
// USI bus bundle: master request/response plus the broadcast slave side.
// 'slave' is the view the matrix uses; 'master' is the view of the MCU and peripherals driving it.
interface usi_bus_matrix_if #(
  parameter int pBusSlaveConnect = 9,
  parameter int pBusDataBit      = 32,
  parameter int pBusAdrsBit      = 16
);
  logic [pBusDataBit-1:0]                  iMUsiWd;
  logic [pBusAdrsBit-1:0]                  iMUsiAdrs;
  logic                                    iMUsiWCke;
  logic                                    iMUsiRCke;
  logic                                    oMUsiRdy;
  logic [pBusDataBit-1:0]                  oMUsiRd;
  logic                                    oMUsiVd;
  logic                                    oMUsiErr;
  logic [pBusDataBit-1:0]                  oSUsiWd;
  logic [pBusAdrsBit-1:0]                  oSUsiAdrs;
  logic [pBusSlaveConnect-1:0]             oSUsiWCke;
  logic [pBusSlaveConnect-1:0]             oSUsiRCke;
  logic [pBusSlaveConnect*pBusDataBit-1:0] iSUsiRd;
  logic [pBusSlaveConnect-1:0]             iSUsiVd;

  modport master (
    output iMUsiWd, iMUsiAdrs, iMUsiWCke, iMUsiRCke, iSUsiRd, iSUsiVd,
    input  oMUsiRdy, oMUsiRd, oMUsiVd, oMUsiErr, oSUsiWd, oSUsiAdrs, oSUsiWCke, oSUsiRCke
  );

  modport slave (
    input  iMUsiWd, iMUsiAdrs, iMUsiWCke, iMUsiRCke, iSUsiRd, iSUsiVd,
    output oMUsiRdy, oMUsiRd, oMUsiVd, oMUsiErr, oSUsiWd, oSUsiAdrs, oSUsiWCke, oSUsiRCke
  );
endinterface

// File: rtl/usi_bus_matrix.sv
// Single-master / N-slave USI interconnect: registered decode, one-hot strobes,
// read-response wait with timeout and an error pulse for unmapped or conflicting requests.
module usi_bus_matrix #(
  parameter int pBusSlaveConnect = 9,
  parameter int pBusDataBit      = 32,
  parameter int pBusAdrsBit      = 16,
  parameter int pBlockAdrsMap    = 8,
  parameter int pAdrsMapBase     = 1,
  parameter int pTimeout         = 255
) (
  input  logic            iUsiClk,
  input  logic            iUsiRst,
  usi_bus_matrix_if.slave bus
);
  localparam int N  = pBusSlaveConnect;
  localparam int D  = pBusDataBit;
  localparam int A  = pBusAdrsBit;
  localparam int B  = pBlockAdrsMap;
  localparam int BW = B + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WSTB  = 3'd1;
  localparam logic [2:0] RSTB  = 3'd2;
  localparam logic [2:0] RWAIT = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  localparam logic [BW-1:0] BASE      = BW'(pAdrsMapBase);
  localparam logic [BW-1:0] NSLV      = BW'(N);
  localparam logic [15:0]   WAIT_LAST = 16'(pTimeout - 1);

  logic [2:0]    state;
  logic          live;
  logic [IW-1:0] idxQ;
  logic [D-1:0]  wdQ;
  logic [D-1:0]  rdQ;
  logic [A-1:0]  adrsQ;
  logic [15:0]   waitCnt;
  logic          errAfterW;
  logic          missToResp;
  logic          respErr;

  logic [B-1:0]  blk;
  logic [BW-1:0] rel;
  logic          hit;
  logic          rdy;
  logic          req;
  logic [IW-1:0] idxDec;

  // One extra bit on the subtraction so block IDs below the base wrap out of range.
  assign blk    = bus.iMUsiAdrs[A-1 -: B];
  assign rel    = {1'b0, blk} - BASE;
  assign hit    = ({1'b0, blk} >= BASE) && (rel < NSLV);
  assign idxDec = rel[IW-1:0];

  logic [D-1:0] slvRd [N];
  for (genvar k = 0; k < N; k++) begin : gSlv
    assign slvRd[k] = bus.iSUsiRd[k*D +: D];
  end

  // live keeps Rdy low through the reset cycle itself.
  assign rdy = live && (state == IDLE);
  assign req = rdy && (bus.iMUsiWCke || bus.iMUsiRCke);

  always_ff @(posedge iUsiClk) begin
    if (iUsiRst) begin
      state      <= IDLE;
      live       <= 1'b0;
      idxQ       <= '0;
      wdQ        <= '0;
      adrsQ      <= '0;
      rdQ        <= '0;
      waitCnt    <= '0;
      errAfterW  <= 1'b0;
      missToResp <= 1'b0;
      respErr    <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: begin
          if (req) begin
            adrsQ      <= bus.iMUsiAdrs;
            wdQ        <= bus.iMUsiWd;
            idxQ       <= idxDec;
            errAfterW  <= bus.iMUsiRCke;
            missToResp <= 1'b0;
            // A write wins over a simultaneous read; the dropped read is reported as an error.
            if (bus.iMUsiWCke) begin
              state <= hit ? WSTB : ERR;
            end else if (hit) begin
              state <= RSTB;
            end else begin
              state      <= ERR;
              missToResp <= 1'b1;
              respErr    <= 1'b1;
              rdQ        <= '0;
            end
          end
        end
        WSTB: state <= errAfterW ? ERR : IDLE;
        RSTB: begin
          waitCnt <= '0;
          state   <= RWAIT;
        end
        RWAIT: begin
          if (bus.iSUsiVd[idxQ]) begin
            rdQ     <= slvRd[idxQ];
            respErr <= 1'b0;
            state   <= RESP;
          end else if (waitCnt == WAIT_LAST) begin
            rdQ     <= '0;
            respErr <= 1'b1;
            state   <= RESP;
          end else begin
            waitCnt <= waitCnt + 16'd1;
          end
        end
        RESP:    state <= IDLE;
        ERR:     state <= missToResp ? RESP : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oMUsiRdy  = rdy;
  assign bus.oMUsiRd   = rdQ;
  assign bus.oMUsiVd   = (state == RESP);
  assign bus.oMUsiErr  = (state == ERR) || ((state == RESP) && respErr);
  assign bus.oSUsiWd   = wdQ;
  assign bus.oSUsiAdrs = adrsQ;
  assign bus.oSUsiWCke = (state == WSTB) ? (N'(1) << idxQ) : '0;
  assign bus.oSUsiRCke = (state == RSTB) ? (N'(1) << idxQ) : '0;
endmodule

// File: tb/tb_usi_bus_matrix.sv
// Scoreboard bench for usi_bus_matrix: a reference model queues the expected bus events
// (with their cycle) per request and a monitor compares everything the DUT emits.
module tb_usi_bus_matrix;
  localparam int N  = 9;
  localparam int D  = 32;
  localparam int A  = 16;
  localparam int TO = 8;

  typedef struct packed {
    logic [31:0]  cyc;
    logic [N-1:0] wcke;
    logic [N-1:0] rcke;
    logic [A-1:0] adrs;
    logic [D-1:0] wd;
    logic         vd;
    logic [D-1:0] rd;
    logic         err;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  bit   started = 1'b0;
  ev_t  expQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  usi_bus_matrix_if #(.pBusSlaveConnect(N), .pBusDataBit(D), .pBusAdrsBit(A)) bus();

  usi_bus_matrix #(
    .pBusSlaveConnect(N), .pBusDataBit(D), .pBusAdrsBit(A),
    .pBlockAdrsMap(8), .pAdrsMapBase(1), .pTimeout(TO)
  ) dut (
    .iUsiClk(clk),
    .iUsiRst(rst),
    .bus(bus)
  );

  task automatic chk(input bit ok, input string name, input string msg);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: %s", name, msg);
  endtask

  function automatic bit decode(input logic [A-1:0] a, output int idx);
    int blk;
    blk = int'(a[A-1 -: 8]);
    idx = blk - 1;
    return (blk >= 1) && (idx < N);
  endfunction

  function automatic void push(input ev_t e, input int abortAt);
    if (int'(e.cyc) < abortAt) expQ.push_back(e);
  endfunction

  // Expected events for one accepted request (accepted at edge tacc, events seen after
  // edge tacc + offset). Returns the first cycle in which Rdy must be back.
  function automatic int model(input logic [A-1:0] a, input logic [D-1:0] wd, input bit w,
                               input bit r, input int d, input logic [D-1:0] rdata,
                               input int tacc, input int abortAt);
    int idx, last;
    bit hit;
    ev_t e;
    hit  = decode(a, idx);
    last = tacc - 1;
    if (w) begin
      if (hit) begin
        e = '0; e.cyc = tacc; e.wcke = N'(1) << idx; e.adrs = a; e.wd = wd;
        push(e, abortAt); last = tacc;
      end
      if (!hit || r) begin
        e = '0; e.cyc = hit ? tacc + 1 : tacc; e.err = 1'b1;
        push(e, abortAt); last = int'(e.cyc);
      end
    end else if (r) begin
      if (hit) begin
        e = '0; e.cyc = tacc; e.rcke = N'(1) << idx; e.adrs = a;
        push(e, abortAt);
        e = '0; e.vd = 1'b1;
        if (d < TO) begin e.cyc = tacc + 2 + d; e.rd = rdata; end
        else begin e.cyc = tacc + 1 + TO; e.rd = '0; e.err = 1'b1; end
        push(e, abortAt); last = int'(e.cyc);
      end else begin
        e = '0; e.cyc = tacc; e.err = 1'b1; push(e, abortAt);
        e = '0; e.cyc = tacc + 1; e.vd = 1'b1; e.err = 1'b1; push(e, abortAt);
        last = tacc + 1;
      end
    end
    return last + 1;
  endfunction

  // Slave side: random noise on every Vd except the selected one, which fires only in
  // RWAIT cycle d (and randomly during the strobe cycle, where it must be ignored).
  task automatic driveSlave(input int c, input int tacc, input bit rdHit, input int idx,
                            input int d, input logic [D-1:0] rdata);
    logic [N*D-1:0] rdv;
    logic [N-1:0]   vdv;
    logic [N-1:0]   sel;
    for (int k = 0; k < N; k++) rdv[k*D +: D] = $urandom;
    vdv = N'($urandom);
    if (rdHit) begin
      sel = N'(1) << idx;
      vdv = vdv & ~sel;
      if (c == tacc + 1 + d || (c == tacc && $urandom_range(0, 1) == 1)) vdv = vdv | sel;
      if (c == tacc + 1 + d) rdv[idx*D +: D] = rdata;
    end
    bus.iSUsiRd = rdv;
    bus.iSUsiVd = vdv;
  endtask

  // Called at a negedge with Rdy high; returns at the negedge where Rdy is back.
  task automatic txn(input logic [A-1:0] a, input logic [D-1:0] wd, input bit w, input bit r,
                     input int d, input logic [D-1:0] rdata);
    int tacc, expFree, idx;
    bit rdHit, got;
    rdHit   = decode(a, idx) && !w && r;
    tacc    = cyc + 1;
    expFree = model(a, wd, w, r, d, rdata, tacc, 32'h7fffffff);
    bus.iMUsiAdrs = a; bus.iMUsiWd = wd; bus.iMUsiWCke = w; bus.iMUsiRCke = r;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      driveSlave(cyc, tacc, rdHit, idx, d, rdata);
      if (bus.oMUsiRdy === 1'b1) begin got = 1'b1; break; end
      // Requests while busy must be ignored.
      bus.iMUsiWCke = 1'($urandom); bus.iMUsiRCke = 1'($urandom);
      bus.iMUsiAdrs = A'($urandom); bus.iMUsiWd = $urandom;
    end
    bus.iMUsiWCke = 1'b0; bus.iMUsiRCke = 1'b0; bus.iSUsiVd = '0;
    chk(got && cyc == expFree, "rdyReturn",
        $sformatf("adrs=%h rdy seen=%0b at cycle %0d, required rdy=1 at cycle %0d", a, got, cyc, expFree));
  endtask

  task automatic idle(input int g);
    repeat (g) @(negedge clk);
  endtask

  function automatic bit allZero();
    return bus.oMUsiRdy === 1'b0 && bus.oMUsiRd === '0 && bus.oMUsiVd === 1'b0 &&
           bus.oMUsiErr === 1'b0 && bus.oSUsiWd === '0 && bus.oSUsiAdrs === '0 &&
           bus.oSUsiWCke === '0 && bus.oSUsiRCke === '0;
  endfunction

  always @(negedge clk) begin : mon
    ev_t o, e;
    bit  act;
    if (started && !rst) begin
      o = '0;
      o.cyc  = cyc;
      o.wcke = bus.oSUsiWCke;
      o.rcke = bus.oSUsiRCke;
      if (o.wcke != '0 || o.rcke != '0) o.adrs = bus.oSUsiAdrs;
      if (o.wcke != '0) o.wd = bus.oSUsiWd;
      o.vd = bus.oMUsiVd;
      if (o.vd) o.rd = bus.oMUsiRd;
      o.err = bus.oMUsiErr;
      act = (o.wcke != '0) || (o.rcke != '0) || o.vd || o.err;
      while (expQ.size() > 0 && int'(expQ[0].cyc) < cyc) begin
        e = expQ.pop_front();
        chk(1'b0, "missingEvent", $sformatf("nothing at cycle %0d, required wcke=%h rcke=%h vd=%b rd=%h err=%b",
            e.cyc, e.wcke, e.rcke, e.vd, e.rd, e.err));
      end
      if (act) begin
        if (expQ.size() == 0) begin
          chk(1'b0, "unexpectedEvent", $sformatf("cycle %0d got wcke=%h rcke=%h vd=%b rd=%h err=%b, required none",
              cyc, o.wcke, o.rcke, o.vd, o.rd, o.err));
        end else begin
          e = expQ.pop_front();
          chk(o === e, "busEvent", $sformatf(
              "got cyc=%0d wcke=%h rcke=%h adrs=%h wd=%h vd=%b rd=%h err=%b, required cyc=%0d wcke=%h rcke=%h adrs=%h wd=%h vd=%b rd=%h err=%b",
              o.cyc, o.wcke, o.rcke, o.adrs, o.wd, o.vd, o.rd, o.err,
              e.cyc, e.wcke, e.rcke, e.adrs, e.wd, e.vd, e.rd, e.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int tacc, op;
    logic [A-1:0] a;
    bus.iMUsiWd = '0; bus.iMUsiAdrs = '0; bus.iMUsiWCke = 1'b0; bus.iMUsiRCke = 1'b0;
    bus.iSUsiRd = '0; bus.iSUsiVd = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk(allZero(), "resetState", $sformatf("rdy=%b vd=%b err=%b wcke=%h rcke=%h, required all outputs 0",
        bus.oMUsiRdy, bus.oMUsiVd, bus.oMUsiErr, bus.oSUsiWCke, bus.oSUsiRCke));
    rst = 1'b0;
    @(negedge clk);
    chk(bus.oMUsiRdy === 1'b1, "rdyAfterReset", $sformatf("rdy=%b, required 1", bus.oMUsiRdy));
    started = 1'b1;

    txn(16'h0104, 32'hA5A5_0001, 1'b1, 1'b0, 0, '0);
    txn(16'h0410, 32'h0, 1'b0, 1'b1, 2, 32'h1234_5678);
    txn(16'h0410, 32'h0, 1'b0, 1'b1, 9, 32'hDEAD_BEEF);
    txn(16'h0A00, 32'h1111_0A00, 1'b1, 1'b0, 0, '0);
    txn(16'h00FF, 32'h1111_00FF, 1'b1, 1'b0, 0, '0);
    txn(16'h0A00, 32'h0, 1'b0, 1'b1, 0, 32'h5555_AAAA);
    txn(16'h00FF, 32'h0, 1'b0, 1'b1, 0, 32'h5555_AAAA);
    txn(16'h0220, 32'h2222_0220, 1'b1, 1'b1, 0, 32'h7777_7777);
    idle(1);
    txn(16'h0A34, 32'h3333_0A34, 1'b1, 1'b1, 0, '0);
    txn(16'h09FE, 32'h9999_0001, 1'b1, 1'b0, 0, '0);
    txn(16'h0900, 32'h0, 1'b0, 1'b1, 0, 32'h0BAD_F00D);
    txn(16'h0100, 32'h0, 1'b0, 1'b1, TO - 1, 32'h0100_0007);
    txn(16'h0100, 32'h0, 1'b0, 1'b1, TO, 32'h0100_0008);

    for (int n = 0; n < 60; n++) begin
      a  = {8'($urandom_range(0, 11)), 8'($urandom)};
      op = $urandom_range(0, 2);
      txn(a, $urandom, op != 1, op != 0, $urandom_range(0, 9), $urandom);
      idle($urandom_range(0, 2));
    end

    // Reset in the second RWAIT cycle aborts the read; the later slave Vd must be dropped.
    tacc = cyc + 1;
    void'(model(16'h0410, 32'h0, 1'b0, 1'b1, 5, 32'hCAFE_F00D, tacc, tacc + 3));
    bus.iMUsiAdrs = 16'h0410; bus.iMUsiRCke = 1'b1;
    @(negedge clk);
    bus.iMUsiRCke = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk(allZero(), "midResetZero", $sformatf("rdy=%b vd=%b err=%b rcke=%h, required all outputs 0",
        bus.oMUsiRdy, bus.oMUsiVd, bus.oMUsiErr, bus.oSUsiRCke));
    bus.iSUsiVd = 9'h008;
    bus.iSUsiRd[3*D +: D] = 32'hCAFE_F00D;
    @(negedge clk);
    chk(allZero(), "midResetHold", $sformatf("rdy=%b vd=%b err=%b, required all outputs 0",
        bus.oMUsiRdy, bus.oMUsiVd, bus.oMUsiErr));
    rst = 1'b0;
    @(negedge clk);
    chk(bus.oMUsiRdy === 1'b1, "rdyAfterMidReset", $sformatf("rdy=%b, required 1", bus.oMUsiRdy));
    repeat (3) @(negedge clk);
    bus.iSUsiVd = '0;
    idle(10);
    chk(expQ.size() == 0, "queueDrained", $sformatf("%0d events pending, required 0", expQ.size()));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/usi_bus_matrix.md
Name: usi_bus_matrix

Overview:
Parametrised single-master / N-slave Ultra Simple Interface interconnect, replacing the fixed 9-slave USI bus with combinational decode.
It adds the following over that bus:
- a ready/request handshake
- registered one-hot slave strobes for both writes and reads
- a read-response wait with timeout
- an error flag for unmapped addresses and protocol faults

It sits between MicroControllerBlock (master side) and the peripheral blocks (GPIO, I2C, PWM, SPI, ...).

Parameters:
pBusSlaveConnect, 9, number of slaves N (1..16); slave k has block ID pAdrsMapBase+k
pBusDataBit, 32, data width D
pBusAdrsBit, 16, address width A (true width, not width-1)
pBlockAdrsMap, 8, number of address MSBs used as block ID (B ≤ A)
pAdrsMapBase, 1, block ID of slave 0
pTimeout, 255, maximum read-wait cycles (≥1, <2^16)

Ports:
iUsiClk  in  1  bus clock; single clock domain
iUsiRst  in  1  synchronous active-high reset
iMUsiWd  in  D  master write data
iMUsiAdrs  in  A  master address
iMUsiWCke  in  1  master write request, sampled only when oMUsiRdy=1
iMUsiRCke  in  1  master read request, sampled only when oMUsiRdy=1
oMUsiRdy  out  1  interconnect idle, request accepted this cycle
oMUsiRd  out  D  read data, valid with oMUsiVd
oMUsiVd  out  1  read response, 1-cycle pulse
oMUsiErr  out  1  error, 1-cycle pulse
oSUsiWd  out  D  registered write data, broadcast to all slaves
oSUsiAdrs  out  A  registered address, broadcast to all slaves
oSUsiWCke  out  N  one-hot write strobe
oSUsiRCke  out  N  one-hot read strobe
iSUsiRd  in  N*D  slave read data, slave k at [k*D +: D]
iSUsiVd  in  N  slave read valid

Behaviour:
- Reset (iUsiRst=1 at a clock edge):
  - state=IDLE.
  - All outputs 0, including oMUsiRdy.
  - oMUsiRdy=1 on the first edge after reset is released.
  - Reset mid-transaction aborts it: no strobe, no oMUsiVd, no oMUsiErr is emitted afterwards.
- Decode:
  - blk = iMUsiAdrs[A-1 -: B]; idx = blk - pAdrsMapBase.
  - hit = (blk ≥ pAdrsMapBase) && (idx < N).
  - Decode is computed on the request cycle and registered with the address and data.
- FSM states: IDLE, WSTB, RSTB, RWAIT, RESP, ERR. oMUsiRdy=1 only in IDLE.
- IDLE, request sampled at edge T:
  - WCke only, hit → WSTB.
  - WCke only, miss → ERR.
  - RCke only, hit → RSTB.
  - RCke only, miss → ERR, then RESP with data 0.
  - WCke and RCke together → write is performed as above; read is dropped; oMUsiErr pulses in the cycle after WSTB (or in the ERR cycle if the write misses).
  - No request → stay in IDLE.
- WSTB (1 cycle, T+1):
  - oSUsiWCke[idx]=1; oSUsiWd and oSUsiAdrs hold the captured values.
  - → IDLE.
  - Write latency: request to strobe is 1 cycle; next request is accepted at T+2.
- RSTB (1 cycle):
  - oSUsiRCke[idx]=1; oSUsiAdrs is valid.
  - 16-bit wait counter cleared to 0.
  - → RWAIT.
- RWAIT:
  - If iSUsiVd[idx]=1: capture iSUsiRd slice idx → RESP.
  - Else if counter==pTimeout-1: data=0, flag timeout → RESP.
  - Else counter+1.
  - iSUsiVd of non-selected slaves is ignored.
  - iSUsiVd during the RSTB cycle is ignored.
- RESP (1 cycle):
  - oMUsiVd=1 with the captured data.
  - oMUsiErr=1 if timeout or read-miss.
  - → IDLE.
- ERR (1 cycle):
  - oMUsiErr=1.
  - → IDLE, or → RESP for a read miss.
- Strobes, oMUsiVd and oMUsiErr are single-cycle pulses, 0 in every other state.
- oSUsiWd and oSUsiAdrs hold their last captured value between transactions.
- oMUsiRd holds its value after oMUsiVd; verification checks it only while oMUsiVd=1.
- At most one strobe bit is ever high, and never WCke and RCke in the same cycle.

Test Plan:
- Write, default parameters: iMUsiAdrs=16'h0104, iMUsiWd=32'hA5A5_0001, WCke at T → at T+1 oSUsiWCke=9'h001, oSUsiAdrs=16'h0104, oSUsiWd=32'hA5A5_0001, oMUsiRdy=0; oMUsiRdy=1 at T+2.
- Read hit: RCke with iMUsiAdrs=16'h0410 → oSUsiRCke=9'h008 for 1 cycle; slave 3 drives Vd with 32'h1234_5678 on the 3rd RWAIT cycle → oMUsiVd=1, oMUsiRd=32'h1234_5678, oMUsiErr=0 on the next cycle; oMUsiRdy returns 1 after it.
- Timeout, pTimeout=8, slave silent: RCke at T → oSUsiRCke at T+1; RWAIT for T+2..T+9; at T+10 oMUsiVd=1, oMUsiRd=0, oMUsiErr=1.
- Unmapped addresses 16'h0A00 and 16'h00FF:
  - Write → no oSUsiWCke bit, 1-cycle oMUsiErr.
  - Read → oMUsiErr, then oMUsiVd with data 0; no oSUsiRCke.
- Simultaneous WCke+RCke on 16'h0220 → only oSUsiWCke=9'h002, oMUsiErr pulse, no oSUsiRCke and no oMUsiVd; also assert that a wrong slave's iSUsiVd during RWAIT is ignored.
- Reset asserted on the 2nd RWAIT cycle → all outputs 0 while in reset; no oMUsiVd even if the slave's Vd arrives later; oMUsiRdy=1 one cycle after reset is released.
